// File: rtl/conv_8x32_comp_unit.sv
// conv_8x32_comp_unit
//
// Frame-based element-wise comparator. After an accepted start, the unit
// compares FRAME_LEN (a_in, b_in) pairs. The compare operation and its
// signedness are latched at start. For each accepted pair it emits a
// registered result one cycle later. Across the frame it keeps a running
// count of true results and records the index of the first true result.
//
// Handshake: a pair is transferred on a rising edge where in_valid && in_ready.
// in_ready is high only while busy (RUN). The source may hold in_valid low for
// any number of cycles. A pair offered while in_ready is low is dropped, not
// stalled.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               frame start request (honoured only when idle)
//   mode[2:0]           0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 always false
//   is_signed           two's-complement ordering for LT/LE/GT/GE
//   in_valid, a_in, b_in, in_ready   operand pair input
//   cmp_valid, cmp_out, cmp_idx      per-element result (latency 1)
//   match_cnt, first_found, first_idx frame statistics, held until next start
//   busy                high while accepting elements
//   done                one-cycle pulse together with the last result
//   dbg_state           current FSM state (0 IDLE, 1 RUN, 2 DONE)
module conv_8x32_comp_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 32,
    parameter int IDX_W      = $clog2(FRAME_LEN),
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic                  is_signed,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  in_ready,
    output logic                  cmp_valid,
    output logic                  cmp_out,
    output logic [IDX_W-1:0]      cmp_idx,
    output logic [CNT_W-1:0]      match_cnt,
    output logic                  first_found,
    output logic [IDX_W-1:0]      first_idx,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       mode_q, mode_d;
    logic             signed_q, signed_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic             cmp_out_q, cmp_out_d;
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             first_found_q, first_found_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;

    logic accept;
    logic last_elem;
    logic result;

    // Operands extended by one bit: the extension is the sign bit when the
    // frame is signed and zero otherwise. A single signed compare then covers
    // both orderings.
    logic signed [DATA_WIDTH:0] a_ext, b_ext;
    logic eq, lt;

    assign accept    = (state_q == S_RUN) && in_valid;
    assign last_elem = (idx_q == IDX_W'(FRAME_LEN - 1));

    always_comb begin
        a_ext = {signed_q & a_in[DATA_WIDTH-1], a_in};
        b_ext = {signed_q & b_in[DATA_WIDTH-1], b_in};
        eq    = (a_in == b_in);
        lt    = (a_ext < b_ext);
        case (mode_q)
            3'd0:    result = eq;
            3'd1:    result = !eq;
            3'd2:    result = lt;
            3'd3:    result = lt || eq;
            3'd4:    result = !(lt || eq);
            3'd5:    result = !lt;
            default: result = 1'b0;
        endcase
    end

    // Next-state FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && last_elem) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        idx_d         = idx_q;
        mode_d        = mode_q;
        signed_d      = signed_q;
        cmp_valid_d   = 1'b0;
        cmp_out_d     = cmp_out_q;
        cmp_idx_d     = cmp_idx_q;
        match_cnt_d   = match_cnt_q;
        first_found_d = first_found_q;
        first_idx_d   = first_idx_q;

        if (state_q == S_IDLE && start) begin
            idx_d         = '0;
            mode_d        = mode;
            signed_d      = is_signed;
            match_cnt_d   = '0;
            first_found_d = 1'b0;
            first_idx_d   = '0;
        end

        // Statistics update on the same edge that registers the result,
        // so they are presented together with cmp_valid.
        if (accept) begin
            cmp_valid_d = 1'b1;
            cmp_out_d   = result;
            cmp_idx_d   = idx_q;
            if (!last_elem) idx_d = idx_q + IDX_W'(1);
            if (result) begin
                if (match_cnt_q != CNT_W'(FRAME_LEN)) match_cnt_d = match_cnt_q + CNT_W'(1);
                if (!first_found_q) begin
                    first_found_d = 1'b1;
                    first_idx_d   = idx_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            mode_q        <= '0;
            signed_q      <= 1'b0;
            cmp_valid_q   <= 1'b0;
            cmp_out_q     <= 1'b0;
            cmp_idx_q     <= '0;
            match_cnt_q   <= '0;
            first_found_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mode_q        <= mode_d;
            signed_q      <= signed_d;
            cmp_valid_q   <= cmp_valid_d;
            cmp_out_q     <= cmp_out_d;
            cmp_idx_q     <= cmp_idx_d;
            match_cnt_q   <= match_cnt_d;
            first_found_q <= first_found_d;
            first_idx_q   <= first_idx_d;
        end
    end

    assign in_ready    = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    // DONE is entered on the edge that registers the last result, so this
    // pulse lines up with the last cmp_valid.
    assign done        = (state_q == S_DONE);
    assign cmp_valid   = cmp_valid_q;
    assign cmp_out     = cmp_out_q;
    assign cmp_idx     = cmp_idx_q;
    assign match_cnt   = match_cnt_q;
    assign first_found = first_found_q;
    assign first_idx   = first_idx_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_conv_8x32_comp_unit.sv
// Testbench for conv_8x32_comp_unit (DATA_WIDTH=8, FRAME_LEN=32).
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// at the same point, i.e. after the edge has settled.
module tb_conv_8x32_comp_unit;

    localparam int DW = 8;
    localparam int FL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic          is_signed;
    logic          in_valid;
    logic [DW-1:0] a_in, b_in;
    logic          in_ready, cmp_valid, cmp_out;
    logic [4:0]    cmp_idx, first_idx;
    logic [5:0]    match_cnt;
    logic          first_found, busy, done;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    conv_8x32_comp_unit #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .is_signed(is_signed),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in), .in_ready(in_ready),
        .cmp_valid(cmp_valid), .cmp_out(cmp_out), .cmp_idx(cmp_idx),
        .match_cnt(match_cnt), .first_found(first_found), .first_idx(first_idx),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: compare two bytes as numbers, per the operation table.
    function automatic bit ref_cmp(input int m, input bit s, input logic [7:0] a, input logic [7:0] b);
        int ai = int'(a);
        int bi = int'(b);
        if (s) begin
            if (a[7]) ai = ai - 256;
            if (b[7]) bi = bi - 256;
        end
        case (m)
            0: return a == b;
            1: return a != b;
            2: return ai < bi;
            3: return ai <= bi;
            4: return ai > bi;
            5: return ai >= bi;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; mode = 3'd0; is_signed = 1'b0;
        a_in = 8'h00; b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        checks++;
        if ({cmp_valid, cmp_out, cmp_idx, match_cnt, first_found, first_idx, busy, done, in_ready, dbg_state} !== 24'h0) begin
            errors++;
            $display("FAIL reset: got %h exp 0",
                     {cmp_valid, cmp_out, cmp_idx, match_cnt, first_found, first_idx, busy, done, in_ready, dbg_state});
        end
    endtask

    // Runs one frame and checks every element.
    // pat: 0 random, 1 all equal, 2 equal only at 5/9/31, 3 near-equal, 4 FF vs 01
    // gap: idle cycles after each element (-1 = random 0..2)
    // inj_start: pulse start with different mode at element 10
    // rst_at: assert reset after this element is accepted (-1 = none)
    task automatic run_frame(input string name, input int m, input bit s, input int gap,
                             input int pat, input bit inj_start, input int rst_at);
        logic [7:0] av[FL];
        logic [7:0] bv[FL];
        bit rv[FL];
        int cnt = 0;
        bit ff = 0;
        int fi = 0;
        int g;
        logic [20:0] obs, exp_v;

        for (int k = 0; k < FL; k++) begin
            av[k] = 8'($urandom_range(0, 255));
            case (pat)
                1: bv[k] = av[k];
                2: bv[k] = (k == 5 || k == 9 || k == 31) ? av[k] : av[k] ^ 8'($urandom_range(1, 255));
                3: case ($urandom_range(0, 3))
                       0: bv[k] = av[k];
                       1: bv[k] = av[k] + 8'd1;
                       2: bv[k] = av[k] - 8'd1;
                       default: bv[k] = 8'($urandom_range(0, 255));
                   endcase
                4: begin av[k] = 8'hFF; bv[k] = 8'h01; end
                default: bv[k] = 8'($urandom_range(0, 255));
            endcase
            rv[k] = ref_cmp(m, s, av[k], bv[k]);
        end

        start = 1'b1; mode = 3'(m); is_signed = s; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, in_ready, match_cnt, first_found, first_idx, cmp_valid, done} !== {2'b11, 6'd0, 1'b0, 5'd0, 2'b00}) begin
            errors++;
            $display("FAIL %s start: got busy=%b rdy=%b cnt=%0d ff=%b fi=%0d v=%b done=%b exp 1 1 0 0 0 0 0",
                     name, busy, in_ready, match_cnt, first_found, first_idx, cmp_valid, done);
        end

        for (int k = 0; k < FL; k++) begin
            a_in = av[k]; b_in = bv[k]; in_valid = 1'b1;
            mode = 3'($urandom_range(0, 7)); is_signed = 1'($urandom_range(0, 1));
            if (inj_start && k == 10) begin
                start = 1'b1;
                mode = (m == 0) ? 3'd1 : 3'd0;
                is_signed = ~s;
            end
            @(posedge clk); #1;
            in_valid = 1'b0; start = 1'b0;
            if (rv[k]) begin
                cnt++;
                if (!ff) begin ff = 1; fi = k; end
            end
            obs   = {cmp_valid, cmp_out, cmp_idx, match_cnt, first_found, first_idx, done, busy};
            exp_v = {1'b1, rv[k], 5'(k), 6'(cnt), ff, 5'(fi), (k == FL - 1), (k != FL - 1)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s elem %0d: got v/out/idx/cnt/ff/fi/done/busy=%h exp %h", name, k, obs, exp_v);
            end

            if (k == rst_at) begin
                rst = 1'b1; start = 1'b1; in_valid = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; in_valid = 1'b0;
                checks++;
                if ({cmp_valid, cmp_out, cmp_idx, match_cnt, first_found, first_idx, busy, done, in_ready, dbg_state} !== 24'h0) begin
                    errors++;
                    $display("FAIL %s mid-frame reset: got %h exp 0", name,
                             {cmp_valid, cmp_out, cmp_idx, match_cnt, first_found, first_idx, busy, done, in_ready, dbg_state});
                end
                return;
            end

            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            if (k == FL - 1) g = 0;
            for (int j = 0; j < g; j++) begin
                a_in = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
                checks++;
                if ({cmp_valid, match_cnt, busy} !== {1'b0, 6'(cnt), 1'b1}) begin
                    errors++;
                    $display("FAIL %s idle after %0d: got v=%b cnt=%0d busy=%b exp 0 %0d 1",
                             name, k, cmp_valid, match_cnt, busy, cnt);
                end
            end
        end

        // Pairs offered in DONE/IDLE must be ignored, statistics must hold.
        in_valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            a_in = 8'($urandom_range(0, 255)); b_in = a_in;
            @(posedge clk); #1;
            checks++;
            if ({cmp_valid, done, busy, in_ready, match_cnt, first_found, first_idx} !==
                {4'b0000, 6'(cnt), ff, 5'(fi)}) begin
                errors++;
                $display("FAIL %s hold %0d: got v=%b done=%b busy=%b rdy=%b cnt=%0d ff=%b fi=%0d exp 0 0 0 0 %0d %b %0d",
                         name, j, cmp_valid, done, busy, in_ready, match_cnt, first_found, first_idx, cnt, ff, fi);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 12; i++)
            run_frame("random", $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1,
                      (i % 2 == 0) ? 3 : 0, 1'($urandom_range(0, 1)), -1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 3'd0; is_signed = 1'b0;
        in_valid = 1'b0; a_in = '0; b_in = '0;
        @(posedge clk); #1;
        test_reset();
        run_frame("eq_sparse",   0, 1'b0, 0, 2, 1'b0, -1);
        run_frame("lt_signed",   2, 1'b1, 0, 4, 1'b0, -1);
        run_frame("lt_unsigned", 2, 1'b0, 0, 4, 1'b0, -1);
        run_frame("ge_gapped",   5, 1'b0, 2, 3, 1'b0, -1);
        run_frame("eq_all",      0, 1'b0, 0, 1, 1'b0, -1);
        run_frame("rsvd6",       6, 1'b0, 0, 1, 1'b0, -1);
        run_frame("rsvd7",       7, 1'b1, 1, 1, 1'b0, -1);
        run_frame("rst_mid",     0, 1'b0, 0, 1, 1'b0, 10);
        run_frame("after_rst",   4, 1'b1, 0, 3, 1'b0, -1);
        run_frame("start_in_run", 3, 1'b1, 0, 3, 1'b1, -1);
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
